// File: rtl/load_store_unit.sv
// Load/store unit: runs one data-memory transaction per request over a req/ack bus.
// Handles byte/half/word sizing, byte-lane steering, load extension, alignment
// checks and an ack timeout. The core stalls while Busy is high.
module load_store_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Busy,
    output logic        Done,
    output logic        Fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t        state_reg, state_next;
    logic          we_reg;
    logic [2:0]    f3_reg;
    logic [31:0]   addr_reg;
    logic [3:0]    be_reg;
    logic [31:0]   wdata_reg;
    logic [CW-1:0] cnt_reg;
    logic          fault_reg;
    logic [31:0]   rdata_reg;

    logic          accept_fault;
    logic [3:0]    be_next;
    wire  [31:0]   wdata_next;
    logic [31:0]   shifted;
    logic [31:0]   load_val;
    logic          timeout_hit;

    // Request screening and byte-enable pattern, computed from the live inputs at acceptance
    always_comb begin
        accept_fault = 1'b0;
        if (Funct3 == 3'b011 || Funct3 == 3'b110 || Funct3 == 3'b111)
            accept_fault = 1'b1;
        if (MemWrite && Funct3[2])
            accept_fault = 1'b1;
        if (Funct3[1:0] == 2'b01 && ALUResult[0])
            accept_fault = 1'b1;
        if (Funct3[1:0] == 2'b10 && ALUResult[1:0] != 2'b00)
            accept_fault = 1'b1;

        case (Funct3[1:0])
            2'b00:   be_next = 4'b0001 << ALUResult[1:0];
            2'b01:   be_next = 4'b0011 << ALUResult[1:0];
            default: be_next = 4'b1111;
        endcase
    end

    // Store data is replicated across lanes so the enabled lanes always carry the right bytes
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam int HALF_LANE = gi % 2;
            assign wdata_next[8*gi +: 8] =
                (Funct3[1:0] == 2'b00) ? WriteData[7:0] :
                (Funct3[1:0] == 2'b01) ? WriteData[8*HALF_LANE +: 8] :
                                         WriteData[8*gi +: 8];
        end
    endgenerate

    // Load extraction: move the addressed bytes to the bottom, then extend
    always_comb begin
        shifted = mem_rdata >> {addr_reg[1:0], 3'b000};
        case (f3_reg)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {24'h000000, shifted[7:0]};
            3'b101:  load_val = {16'h0000, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    assign timeout_hit = (cnt_reg == CNT_LAST);

    // Next-state logic for the IDLE -> REQ -> DONE sequence
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (Start) state_next = accept_fault ? DONE : REQ;
            REQ:  if (mem_ack || timeout_hit) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, request capture, timeout counter, fault flag and load result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            we_reg    <= 1'b0;
            f3_reg    <= 3'b000;
            addr_reg  <= 32'h0;
            be_reg    <= 4'h0;
            wdata_reg <= 32'h0;
            cnt_reg   <= '0;
            fault_reg <= 1'b0;
            rdata_reg <= 32'h0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        we_reg    <= MemWrite;
                        f3_reg    <= Funct3;
                        addr_reg  <= ALUResult;
                        be_reg    <= be_next;
                        wdata_reg <= wdata_next;
                        cnt_reg   <= '0;
                        fault_reg <= accept_fault;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        fault_reg <= 1'b0;
                        if (!we_reg)
                            rdata_reg <= load_val;
                    end else if (timeout_hit) begin
                        fault_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: fault_reg <= 1'b0;
            endcase
        end
    end

    // Bus outputs are gated by the state so they read zero outside an active request
    assign mem_req   = (state_reg == REQ);
    assign mem_we    = mem_req & we_reg;
    assign mem_addr  = mem_req ? {addr_reg[31:2], 2'b00} : 32'h0;
    assign mem_be    = mem_req ? be_reg : 4'h0;
    assign mem_wdata = mem_req ? wdata_reg : 32'h0;

    assign Busy     = (state_reg != IDLE);
    assign Done     = (state_reg == DONE);
    assign Fault    = fault_reg & Done;
    assign ReadData = rdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with hand-computed expected values.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Start = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  Funct3 = 3'b000;
    logic [31:0] ALUResult = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic        Busy;
    logic        Done;
    logic        Fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Busy      (Busy),
        .Done      (Done),
        .Fault     (Fault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Results of the most recent access
    int          r_done;
    int          r_reqs;
    logic        r_fault;
    logic [31:0] r_rdata;
    logic [3:0]  r_be;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic        r_stable;

    // Called #1 after a rising edge with the DUT idle; that cycle is cycle 0.
    task automatic run_access(input string tag, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int ack_at, input bit spam);
        Start = 1'b1; MemWrite = we; Funct3 = f3; ALUResult = addr; WriteData = wd;
        mem_ack = 1'b0;
        r_done = -1; r_reqs = 0; r_fault = 1'b0; r_rdata = 32'h0;
        r_be = 4'h0; r_addr = 32'h0; r_wdata = 32'h0; r_we = 1'b0; r_stable = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            Start = 1'b0; MemWrite = ~we; Funct3 = 3'b111;
            ALUResult = 32'hFFFF_FFFF; WriteData = ~wd;
            if (mem_req) begin
                r_reqs++;
                if (r_reqs == 1) begin
                    r_be = mem_be; r_addr = mem_addr; r_wdata = mem_wdata; r_we = mem_we;
                end else if (mem_be !== r_be || mem_addr !== r_addr ||
                             mem_wdata !== r_wdata || mem_we !== r_we) begin
                    r_stable = 1'b0;
                end
            end
            if (spam && Busy) begin
                Start = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h300;
            end
            if (Done) begin
                r_done = c; r_fault = Fault; r_rdata = ReadData;
                mem_ack = 1'b0;
                break;
            end
            mem_ack   = (c == ack_at);
            mem_rdata = (c == ack_at) ? rd : 32'h5A5A_5A5A;
        end
        mem_ack = 1'b0;
        @(posedge clk); #1;
        Start = 1'b0;
        check_eq({tag, " idle_busy"}, {31'h0, Busy}, 32'h0);
        check_eq({tag, " idle_done"}, {31'h0, Done}, 32'h0);
        $display("txn %s: done_cycle=%0d req_cycles=%0d fault=%0d rdata=0x%08h be=%b addr=0x%08h wdata=0x%08h we=%0d",
                 tag, r_done, r_reqs, r_fault, r_rdata, r_be, r_addr, r_wdata, r_we);
    endtask

    // Checks common to every access outcome
    task automatic check_outcome(input string tag, input int exp_done, input int exp_reqs,
                                 input logic exp_fault, input logic [31:0] exp_rdata);
        check_eq({tag, " done_cycle"}, 32'(r_done), 32'(exp_done));
        check_eq({tag, " req_cycles"}, 32'(r_reqs), 32'(exp_reqs));
        check_eq({tag, " fault"}, {31'h0, r_fault}, {31'h0, exp_fault});
        check_eq({tag, " read_data"}, r_rdata, exp_rdata);
    endtask

    // Checks on the bus signals seen during the request
    task automatic check_bus(input string tag, input logic exp_we, input logic [3:0] exp_be,
                             input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
        check_eq({tag, " mem_we"}, {31'h0, r_we}, {31'h0, exp_we});
        check_eq({tag, " mem_be"}, {28'h0, r_be}, {28'h0, exp_be});
        check_eq({tag, " mem_addr"}, r_addr, exp_addr);
        if (exp_we)
            check_eq({tag, " mem_wdata"}, r_wdata, exp_wdata);
        check_eq({tag, " bus_stable"}, {31'h0, r_stable}, 32'h1);
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset busy", {31'h0, Busy}, 32'h0);
        check_eq("reset done", {31'h0, Done}, 32'h0);
        check_eq("reset fault", {31'h0, Fault}, 32'h0);
        check_eq("reset mem_req", {31'h0, mem_req}, 32'h0);
        check_eq("reset read_data", ReadData, 32'h0);
        check_eq("reset mem_be", {28'h0, mem_be}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Ack while idle is ignored
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check_eq("idle_ack busy", {31'h0, Busy}, 32'h0);
        check_eq("idle_ack read_data", ReadData, 32'h0);

        // Loads
        run_access("lw_100", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, 1'b0);
        check_outcome("lw_100", 2, 1, 1'b0, 32'hDEAD_BEEF);
        check_bus("lw_100", 1'b0, 4'b1111, 32'h100, 32'h0);

        run_access("lb_103", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 2, 1'b0);
        check_outcome("lb_103", 3, 2, 1'b0, 32'hFFFF_FF80);
        check_bus("lb_103", 1'b0, 4'b1000, 32'h100, 32'h0);

        run_access("lbu_103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1, 1'b0);
        check_outcome("lbu_103", 2, 1, 1'b0, 32'h0000_0080);

        run_access("lh_002", 1'b0, 3'b001, 32'h002, 32'h0, 32'h80FF_0000, 3, 1'b0);
        check_outcome("lh_002", 4, 3, 1'b0, 32'hFFFF_80FF);
        check_bus("lh_002", 1'b0, 4'b1100, 32'h0, 32'h0);

        run_access("lhu_002", 1'b0, 3'b101, 32'h002, 32'h0, 32'h80FF_0000, 1, 1'b0);
        check_outcome("lhu_002", 2, 1, 1'b0, 32'h0000_80FF);

        // Stores leave ReadData untouched
        run_access("sh_202", 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h1111_1111, 2, 1'b0);
        check_outcome("sh_202", 3, 2, 1'b0, 32'h0000_80FF);
        check_bus("sh_202", 1'b1, 4'b1100, 32'h200, 32'hABCD_ABCD);

        run_access("sb_101", 1'b1, 3'b000, 32'h101, 32'h0000_0077, 32'h2222_2222, 1, 1'b0);
        check_outcome("sb_101", 2, 1, 1'b0, 32'h0000_80FF);
        check_bus("sb_101", 1'b1, 4'b0010, 32'h100, 32'h7777_7777);

        run_access("sw_10c", 1'b1, 3'b010, 32'h10C, 32'hCAFE_F00D, 32'h3333_3333, 1, 1'b0);
        check_outcome("sw_10c", 2, 1, 1'b0, 32'h0000_80FF);
        check_bus("sw_10c", 1'b1, 4'b1111, 32'h10C, 32'hCAFE_F00D);

        // Faults at acceptance: no bus request, Done+Fault in cycle 1
        run_access("lw_mis", 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1, 1'b0);
        check_outcome("lw_mis", 1, 0, 1'b1, 32'h0000_80FF);
        run_access("lh_mis", 1'b0, 3'b001, 32'h001, 32'h0, 32'h0, 1, 1'b0);
        check_outcome("lh_mis", 1, 0, 1'b1, 32'h0000_80FF);
        run_access("st_f100", 1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 1, 1'b0);
        check_outcome("st_f100", 1, 0, 1'b1, 32'h0000_80FF);
        run_access("ld_f011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1'b0);
        check_outcome("ld_f011", 1, 0, 1'b1, 32'h0000_80FF);

        // Timeout with Start pulses while busy
        run_access("lw_tmo", 1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 0, 1'b1);
        check_outcome("lw_tmo", 16, 15, 1'b1, 32'h0000_80FF);
        check_bus("lw_tmo", 1'b0, 4'b1111, 32'h500, 32'h0);

        // Reset in the middle of a request
        Start = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h400;
        @(posedge clk); #1;
        Start = 1'b0;
        check_eq("rst_req mem_req_before", {31'h0, mem_req}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_req mem_req_after", {31'h0, mem_req}, 32'h0);
        check_eq("rst_req busy", {31'h0, Busy}, 32'h0);
        check_eq("rst_req read_data", ReadData, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_eq("rst_req no_done", {31'h0, Done}, 32'h0);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_eq("rst_rel no_done", {31'h0, Done}, 32'h0);
        end
        run_access("lw_after_rst", 1'b0, 3'b010, 32'h010, 32'h0, 32'h1357_9BDF, 3, 1'b0);
        check_outcome("lw_after_rst", 4, 3, 1'b0, 32'h1357_9BDF);
        check_bus("lw_after_rst", 1'b0, 4'b1111, 32'h010, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
